// File: rtl/seg_scan_sequencer_pkg.sv
// Shared display constants for the position readout.
// Segment patterns are active-low {a,b,c,d,e,f,g,dp}.
package seg_scan_sequencer_pkg;

    localparam logic [7:0] SEG_0     = 8'b0000_0011;
    localparam logic [7:0] SEG_1     = 8'b1001_1111;
    localparam logic [7:0] SEG_2     = 8'b0010_0101;
    localparam logic [7:0] SEG_3     = 8'b0000_1101;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b0100_1001;
    localparam logic [7:0] SEG_6     = 8'b0100_0001;
    localparam logic [7:0] SEG_7     = 8'b0001_1111;
    localparam logic [7:0] SEG_8     = 8'b0000_0001;
    localparam logic [7:0] SEG_9     = 8'b0001_1001;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;
    localparam logic [7:0] SEG_DASH  = 8'b1111_1101;

    localparam logic [2:0] EN_HUND  = 3'b011;
    localparam logic [2:0] EN_TENS  = 3'b101;
    localparam logic [2:0] EN_UNITS = 3'b110;
    localparam logic [2:0] EN_NONE  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT
    } conv_state_t;

    typedef enum logic [1:0] {
        SLOT_HUND,
        SLOT_TENS,
        SLOT_UNITS
    } slot_t;

    function automatic logic [7:0] digit_pattern(input logic [3:0] n);
        logic [7:0] p;
        unique case (n)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg_scan_sequencer_bcd_to_seg.sv
// Nibble to seven-segment decoder with blank and dash overrides.
// Dash has priority over blank; non-decimal nibbles show blank.
module bcd_to_seg
    import seg_scan_sequencer_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dash,
    output logic [7:0] pattern
);

    // Pick the pattern for one digit
    always_comb begin
        pattern = SEG_BLANK;
        if (dash) begin
            pattern = SEG_DASH;
        end else if (!blank) begin
            pattern = digit_pattern(nibble);
        end
    end

endmodule

// File: rtl/seg_scan_sequencer.sv
// Conversion handshake and 3-digit multiplexed display scan.
// Every register runs on Clk; outputs are registered.
module seg_scan_sequencer
    import seg_scan_sequencer_pkg::*;
#(
    parameter int INPUT_WIDTH   = 13,
    parameter int REFRESH_DIV   = 65536,
    parameter int TIMEOUT       = 1024,
    parameter int BLANK_LEADING = 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [INPUT_WIDTH-1:0] i_Value,
    output logic                   o_Start,
    input  logic [15:0]            i_BCD,
    input  logic                   i_DV,
    output logic [2:0]             o_Enable,
    output logic [7:0]             o_SevenSegment,
    output logic                   o_Timeout
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [PW-1:0]          presc;
    logic [PW-1:0]          presc_nx;
    slot_t                  slot;
    slot_t                  slot_nx;
    logic                   slot_tick;
    logic                   frame_tick;

    conv_state_t            state;
    conv_state_t            state_nx;
    logic [TW-1:0]          wait_cnt;
    logic [TW-1:0]          wait_cnt_nx;
    logic [INPUT_WIDTH-1:0] last_value;
    logic [INPUT_WIDTH-1:0] last_value_nx;
    logic                   have_result;
    logic                   have_result_nx;
    logic [15:0]            disp_bcd;
    logic [15:0]            disp_bcd_nx;
    logic                   timeout_nx;

    logic [3:0]             nibble;
    logic                   lead_blank;
    logic                   dash;
    logic [7:0]             pattern;
    logic [2:0]             en_nx;
    logic [7:0]             seg_nx;

    // Slot timing: prescaler wrap advances hundreds -> tens -> units
    always_comb begin
        slot_tick = (presc == PW'(REFRESH_DIV - 1));
        presc_nx  = slot_tick ? '0 : presc + PW'(1);
        slot_nx   = slot;
        if (slot_tick) begin
            unique case (slot)
                SLOT_HUND: slot_nx = SLOT_TENS;
                SLOT_TENS: slot_nx = SLOT_UNITS;
                default:   slot_nx = SLOT_HUND;
            endcase
        end
        frame_tick = slot_tick && (slot == SLOT_UNITS);
    end

    // Conversion FSM: start on frame tick, latch on DV or give up
    // The wait counter counts cycles since the start pulse began.
    always_comb begin
        state_nx       = state;
        wait_cnt_nx    = wait_cnt;
        last_value_nx  = last_value;
        have_result_nx = have_result;
        disp_bcd_nx    = disp_bcd;
        timeout_nx     = o_Timeout;
        unique case (state)
            ST_IDLE: begin
                if (frame_tick &&
                    (!have_result || i_Value != last_value)) begin
                    last_value_nx = i_Value;
                    wait_cnt_nx   = '0;
                    state_nx      = ST_START;
                end
            end
            ST_START: begin
                wait_cnt_nx = wait_cnt + TW'(1);
                state_nx    = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_DV) begin
                    disp_bcd_nx    = i_BCD;
                    have_result_nx = 1'b1;
                    state_nx       = ST_IDLE;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    timeout_nx     = 1'b1;
                    have_result_nx = 1'b0;
                    state_nx       = ST_IDLE;
                end else begin
                    wait_cnt_nx = wait_cnt + TW'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Select the digit for the upcoming slot and its blanking
    always_comb begin
        dash       = (disp_bcd[15:12] != 4'd0);
        nibble     = disp_bcd[3:0];
        lead_blank = 1'b0;
        en_nx      = EN_UNITS;
        unique case (slot_nx)
            SLOT_HUND: begin
                nibble     = disp_bcd[11:8];
                lead_blank = (BLANK_LEADING != 0) &&
                             (disp_bcd[11:8] == 4'd0);
                en_nx      = EN_HUND;
            end
            SLOT_TENS: begin
                nibble     = disp_bcd[7:4];
                lead_blank = (BLANK_LEADING != 0) &&
                             (disp_bcd[11:8] == 4'd0) &&
                             (disp_bcd[7:4] == 4'd0);
                en_nx      = EN_TENS;
            end
            default: ;
        endcase
        if (presc_nx == '0) begin
            en_nx = EN_NONE;
        end
    end

    bcd_to_seg u_dec (
        .nibble  (nibble),
        .blank   (lead_blank),
        .dash    (dash),
        .pattern (pattern)
    );

    // Pattern is loaded once per slot so a digit never changes mid-slot
    always_comb begin
        seg_nx = o_SevenSegment;
        if (presc_nx == '0) begin
            seg_nx = SEG_BLANK;
        end else if (presc_nx == PW'(1)) begin
            seg_nx = pattern;
        end
    end

    // Scan counters
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            presc <= '0;
            slot  <= SLOT_HUND;
        end else begin
            presc <= presc_nx;
            slot  <= slot_nx;
        end
    end

    // Conversion state
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            last_value  <= '0;
            have_result <= 1'b0;
            disp_bcd    <= '0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            last_value  <= last_value_nx;
            have_result <= have_result_nx;
            disp_bcd    <= disp_bcd_nx;
        end
    end

    // Output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            o_Start        <= 1'b0;
            o_Enable       <= EN_NONE;
            o_SevenSegment <= SEG_BLANK;
            o_Timeout      <= 1'b0;
        end else begin
            o_Start        <= (state_nx == ST_START);
            o_Enable       <= en_nx;
            o_SevenSegment <= seg_nx;
            o_Timeout      <= timeout_nx;
        end
    end

endmodule
